// File: rtl/axil_ram_bist_if.sv
// AXI4-Lite bus bundle between the BIST master and the RAM slave.
// Handshake rule on every channel: a transfer happens on a rising clk edge
// where both valid and ready are high. The source keeps valid high and its
// payload unchanged until that edge, and it may lower valid only afterwards.
// The sink may drive ready at any time, including before valid rises.
interface axil_ram_bist_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axil_ram_bist.sv
// AXI4-Lite RAM self-test master. It writes seed+i to each word of a
// contiguous range, reads every word back, and reports the pass flag, a
// saturating error count and the first failing address. Only one
// transaction is outstanding at any time.
module axil_ram_bist #(
  parameter int                DATA_WIDTH = 32,
  parameter int                ADDR_WIDTH = 16,
  parameter int                STRB_WIDTH = DATA_WIDTH / 8,
  parameter longint unsigned   BASE_ADDR  = 0,
  parameter int                WORD_COUNT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           err_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            dbg_state_o,
  axil_ram_bist_if.master       m_axil
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD      = 3'd3,
    S_RD_DATA = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [15:0] LAST_IDX = 16'(WORD_COUNT - 1);

  state_t                state_q;
  logic [15:0]           idx_q;
  logic [DATA_WIDTH-1:0] seed_q;
  logic                  busy_q, done_q, pass_q;
  logic [15:0]           err_q;
  logic [ADDR_WIDTH-1:0] fail_q;
  logic                  awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic [ADDR_WIDTH-1:0] awaddr_q, araddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic                  is_last_d;
  logic [15:0]           idx_nxt_d;
  logic [ADDR_WIDTH-1:0] nxt_addr_d;
  logic [DATA_WIDTH-1:0] nxt_data_d;
  logic [DATA_WIDTH-1:0] exp_data_d;
  logic                  wr_err_d, rd_err_d;
  logic [15:0]           err_inc_d;
  logic                  aw_ok_d, w_ok_d;

  // Byte address of word i, wrapping at the address width.
  function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [15:0] i);
    logic [63:0] a;
    a = 64'(BASE_ADDR) + 64'(i) * 64'(STRB_WIDTH);
    return a[ADDR_WIDTH-1:0];
  endfunction

  // Next-word payload, read-back compare and saturating error increment.
  always_comb begin
    is_last_d  = (idx_q == LAST_IDX);
    idx_nxt_d  = idx_q + 16'd1;
    nxt_addr_d = word_addr(idx_nxt_d);
    nxt_data_d = seed_q + DATA_WIDTH'(idx_nxt_d);
    exp_data_d = seed_q + DATA_WIDTH'(idx_q);
    wr_err_d   = (m_axil.bresp != 2'b00);
    rd_err_d   = (m_axil.rresp != 2'b00) || (m_axil.rdata != exp_data_d);
    err_inc_d  = (err_q == 16'hFFFF) ? err_q : (err_q + 16'd1);
    aw_ok_d    = !awvalid_q || m_axil.awready;
    w_ok_d     = !wvalid_q || m_axil.wready;
  end

  // Test sequencer: write pass, read/compare pass, then publish the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      seed_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= '0;
      fail_q    <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            seed_q    <= seed;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= '0;
            fail_q    <= '0;
            busy_q    <= 1'b1;
            idx_q     <= '0;
            awaddr_q  <= word_addr(16'd0);
            wdata_q   <= seed;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            state_q   <= S_WR;
          end
        end
        S_WR: begin
          // Address and data channels retire independently, in any order.
          if (awvalid_q && m_axil.awready) awvalid_q <= 1'b0;
          if (wvalid_q && m_axil.wready)   wvalid_q  <= 1'b0;
          if (aw_ok_d && w_ok_d) begin
            bready_q <= 1'b1;
            state_q  <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (m_axil.bvalid) begin
            bready_q <= 1'b0;
            if (wr_err_d) begin
              err_q <= err_inc_d;
              if (err_q == 16'd0) fail_q <= awaddr_q;
            end
            if (is_last_d) begin
              idx_q     <= '0;
              araddr_q  <= word_addr(16'd0);
              arvalid_q <= 1'b1;
              state_q   <= S_RD;
            end else begin
              idx_q     <= idx_nxt_d;
              awaddr_q  <= nxt_addr_d;
              wdata_q   <= nxt_data_d;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= S_WR;
            end
          end
        end
        S_RD: begin
          if (m_axil.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (m_axil.rvalid) begin
            rready_q <= 1'b0;
            // A beat with both a bad response and bad data counts once.
            if (rd_err_d) begin
              err_q <= err_inc_d;
              if (err_q == 16'd0) fail_q <= araddr_q;
            end
            if (is_last_d) begin
              state_q <= S_DONE;
            end else begin
              idx_q     <= idx_nxt_d;
              araddr_q  <= nxt_addr_d;
              arvalid_q <= 1'b1;
              state_q   <= S_RD;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          pass_q  <= (err_q == 16'd0);
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign m_axil.awaddr  = awaddr_q;
  assign m_axil.awprot  = 3'b000;
  assign m_axil.awvalid = awvalid_q;
  assign m_axil.wdata   = wdata_q;
  assign m_axil.wstrb   = '1;
  assign m_axil.wvalid  = wvalid_q;
  assign m_axil.bready  = bready_q;
  assign m_axil.araddr  = araddr_q;
  assign m_axil.arprot  = 3'b000;
  assign m_axil.arvalid = arvalid_q;
  assign m_axil.rready  = rready_q;

  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign err_count   = err_q;
  assign fail_addr   = fail_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_axil_ram_bist.sv
// Bench for axil_ram_bist: a 4-word AXI4-Lite RAM slave with programmable
// ready/response delays and fault injection, plus a scoreboard of the
// expected write and read-address beats.
`timescale 1ns/1ps
module tb_axil_ram_bist;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int SW = DW / 8;
  localparam int WC = 4;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] seed = '0;
  logic          busy, done, pass;
  logic [15:0]   err_count;
  logic [AW-1:0] fail_addr;
  logic [2:0]    dbg_state;

  always #5 clk = ~clk;

  axil_ram_bist_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) axil ();

  axil_ram_bist #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(0), .WORD_COUNT(WC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_addr(fail_addr), .dbg_state_o(dbg_state), .m_axil(axil)
  );

  int checks = 0;
  int failures = 0;

  // ---------------- slave model configuration ----------------
  int          aw_delay = 0, w_delay = 0, b_delay = 0;
  logic [WC-1:0] corrupt_r = '0, bresp_err = '0, rresp_err = '0;

  // ---------------- scoreboard ----------------
  logic [AW+DW-1:0] exp_wr_q[$];
  logic [AW-1:0]    exp_rd_q[$];
  int sb_errs = 0, proto_errs = 0, w_before_aw = 0;

  logic [DW-1:0] mem [WC];
  logic          p_awvalid, p_wvalid, p_bready, p_arvalid, p_rready;
  logic [AW-1:0] p_awaddr, p_araddr;
  logic [DW-1:0] p_wdata;
  logic [SW-1:0] p_wstrb;
  logic [2:0]    p_awprot, p_arprot;
  logic          aw_got, w_got, wr_logged, b_pend, r_pend;
  int            aw_cnt, w_cnt, b_cnt;
  logic [AW-1:0] wr_addr_c, rd_addr_c;
  logic [DW-1:0] wr_data_c;
  logic [SW-1:0] wr_strb_c;
  logic [2:0]    wr_prot_c;

  // Slave: acts on the falling edge; handshakes are inferred from the
  // master outputs snapshotted on the previous falling edge.
  always @(negedge clk) begin : slave
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [AW+DW-1:0] exp_w;
    logic [AW-1:0] exp_a;
    int wi;
    if (!rst_n) begin
      axil.awready = 0; axil.wready = 0; axil.bvalid = 0; axil.bresp = 0;
      axil.arready = 0; axil.rvalid = 0; axil.rresp = 0; axil.rdata = 0;
      p_awvalid = 0; p_wvalid = 0; p_bready = 0; p_arvalid = 0; p_rready = 0;
      p_awaddr = 0; p_araddr = 0; p_wdata = 0; p_wstrb = 0; p_awprot = 0; p_arprot = 0;
      aw_got = 0; w_got = 0; wr_logged = 0; b_pend = 0; r_pend = 0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    end else begin
      aw_hs = p_awvalid && axil.awready;
      w_hs  = p_wvalid && axil.wready;
      b_hs  = axil.bvalid && p_bready;
      ar_hs = p_arvalid && axil.arready;
      r_hs  = axil.rvalid && p_rready;
      // valid must hold with a stable payload until accepted
      if (p_awvalid && !aw_hs && (!axil.awvalid || axil.awaddr !== p_awaddr)) begin
        proto_errs++; $display("  protocol: aw changed before accept at %0t", $time);
      end
      if (p_wvalid && !w_hs && (!axil.wvalid || axil.wdata !== p_wdata)) begin
        proto_errs++; $display("  protocol: w changed before accept at %0t", $time);
      end
      if (p_arvalid && !ar_hs && (!axil.arvalid || axil.araddr !== p_araddr)) begin
        proto_errs++; $display("  protocol: ar changed before accept at %0t", $time);
      end
      // valid must drop the cycle after its own handshake
      if ((aw_hs && axil.awvalid) || (w_hs && axil.wvalid) || (ar_hs && axil.arvalid)) begin
        proto_errs++; $display("  protocol: valid held after handshake at %0t", $time);
      end
      if (b_hs) begin
        axil.bvalid = 0; aw_got = 0; w_got = 0; wr_logged = 0;
      end
      if (aw_hs) begin
        axil.awready = 0; aw_got = 1; wr_addr_c = p_awaddr; wr_prot_c = p_awprot;
      end else if (axil.awvalid && !axil.awready && !aw_got) begin
        if (aw_cnt >= aw_delay) begin axil.awready = 1; aw_cnt = 0; end
        else aw_cnt++;
      end
      if (w_hs) begin
        if (!aw_got) w_before_aw++;
        axil.wready = 0; w_got = 1; wr_data_c = p_wdata; wr_strb_c = p_wstrb;
      end else if (axil.wvalid && !axil.wready && !w_got) begin
        if (w_cnt >= w_delay) begin axil.wready = 1; w_cnt = 0; end
        else w_cnt++;
      end
      if (aw_got && w_got && !wr_logged) begin
        wr_logged = 1; b_pend = 1; b_cnt = 0;
        wi = int'(wr_addr_c[3:2]);
        mem[wi] = wr_data_c;
        if (exp_wr_q.size() == 0) begin
          sb_errs++; $display("  scoreboard: unexpected write %h", wr_addr_c);
        end else begin
          exp_w = exp_wr_q.pop_front();
          if ({wr_addr_c, wr_data_c} !== exp_w || wr_prot_c !== 3'b000 || wr_strb_c !== '1) begin
            sb_errs++;
            $display("  scoreboard: write got %h prot %b strb %b want %h", {wr_addr_c, wr_data_c}, wr_prot_c, wr_strb_c, exp_w);
          end
        end
      end
      if (b_pend) begin
        if (b_cnt >= b_delay) begin
          wi = int'(wr_addr_c[3:2]);
          axil.bvalid = 1; axil.bresp = bresp_err[wi] ? 2'b10 : 2'b00; b_pend = 0;
        end else b_cnt++;
      end
      if (r_hs) axil.rvalid = 0;
      if (ar_hs) begin
        axil.arready = 0; rd_addr_c = p_araddr; r_pend = 1;
        if (exp_rd_q.size() == 0) begin
          sb_errs++; $display("  scoreboard: unexpected read %h", p_araddr);
        end else begin
          exp_a = exp_rd_q.pop_front();
          if (p_araddr !== exp_a || p_arprot !== 3'b000) begin
            sb_errs++; $display("  scoreboard: read addr got %h prot %b want %h", p_araddr, p_arprot, exp_a);
          end
        end
      end else if (axil.arvalid && !axil.arready && !r_pend && !axil.rvalid) begin
        axil.arready = 1;
      end
      if (r_pend) begin
        wi = int'(rd_addr_c[3:2]);
        axil.rdata  = mem[wi] ^ (corrupt_r[wi] ? 32'h0000_0100 : 32'h0);
        axil.rresp  = rresp_err[wi] ? 2'b10 : 2'b00;
        axil.rvalid = 1; r_pend = 0;
      end
      p_awvalid = axil.awvalid; p_wvalid = axil.wvalid; p_bready = axil.bready;
      p_arvalid = axil.arvalid; p_rready = axil.rready;
      p_awaddr = axil.awaddr; p_araddr = axil.araddr; p_wdata = axil.wdata;
      p_wstrb = axil.wstrb; p_awprot = axil.awprot; p_arprot = axil.arprot;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_expected(input logic [DW-1:0] s);
    for (int i = 0; i < WC; i++) begin
      logic [AW-1:0] a;
      a = AW'(i * SW);
      exp_wr_q.push_back({a, s + DW'(i)});
      exp_rd_q.push_back(a);
    end
  endtask

  task automatic pulse_start(input logic [DW-1:0] s);
    @(negedge clk);
    start = 1'b1; seed = s;
    @(negedge clk);
    start = 1'b0; seed = $urandom;
  endtask

  task automatic wait_done(input int budget, output int cycles, output bit timed_out);
    cycles = 0; timed_out = 0;
    while (!done) begin
      @(negedge clk);
      cycles++;
      if (cycles >= budget) begin timed_out = 1; break; end
    end
  endtask

  task automatic run_test(input logic [DW-1:0] s, output int cycles, output bit timed_out);
    push_expected(s);
    pulse_start(s);
    wait_done(400, cycles, timed_out);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({busy, done, pass} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b want=000", {busy, done, pass}); end
    checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL reset_err_count got=%h want=0000", err_count); end
    checks++; if (fail_addr !== 16'd0) begin failures++; $display("FAIL reset_fail_addr got=%h want=0000", fail_addr); end
    checks++; if ({axil.awvalid, axil.wvalid, axil.bready, axil.arvalid, axil.rready} !== 5'b0) begin
      failures++; $display("FAIL reset_valids got=%b want=00000", {axil.awvalid, axil.wvalid, axil.bready, axil.arvalid, axil.rready});
    end
    checks++; if (dbg_state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d want=0", dbg_state); end
    rst_n = 1'b1;
    repeat ($urandom_range(2, 4)) @(negedge clk);
    checks++; if ({busy, axil.awvalid} !== 2'b00) begin failures++; $display("FAIL idle_no_start got=%b want=00", {busy, axil.awvalid}); end
  endtask

  task automatic test_clean();
    int cyc; bit to;
    run_test(32'h1000_0000, cyc, to);
    checks++; if (to) begin failures++; $display("FAIL clean_timeout got=%0d cycles want=done", cyc); end
    checks++; if ({pass, busy} !== 2'b10) begin failures++; $display("FAIL clean_pass got=%b want=10", {pass, busy}); end
    checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL clean_err_count got=%h want=0000", err_count); end
    checks++; if (fail_addr !== 16'd0) begin failures++; $display("FAIL clean_fail_addr got=%h want=0000", fail_addr); end
    for (int i = 0; i < WC; i++) begin
      checks++; if (mem[i] !== 32'h1000_0000 + DW'(i)) begin failures++; $display("FAIL clean_mem%0d got=%h want=%h", i, mem[i], 32'h1000_0000 + DW'(i)); end
    end
    checks++; if (cyc > 40) begin failures++; $display("FAIL clean_latency got=%0d want<=40", cyc); end
    repeat (5) @(negedge clk);
    checks++; if ({done, pass, busy} !== 3'b110) begin failures++; $display("FAIL done_sticky got=%b want=110", {done, pass, busy}); end
    checks++; if (exp_wr_q.size() + exp_rd_q.size() != 0) begin failures++; $display("FAIL clean_queue_left got=%0d want=0", exp_wr_q.size() + exp_rd_q.size()); end
    checks++; if (sb_errs + proto_errs != 0) begin failures++; $display("FAIL clean_scoreboard got=%0d want=0", sb_errs + proto_errs); end
  endtask

  task automatic test_slow_aw();
    int cyc; bit to; int wb0;
    aw_delay = 3; w_delay = 0; b_delay = 5;
    wb0 = w_before_aw;
    run_test(32'h1000_0000, cyc, to);
    checks++; if (to) begin failures++; $display("FAIL slow_aw_timeout got=%0d cycles want=done", cyc); end
    checks++; if ({pass, err_count} !== {1'b1, 16'd0}) begin failures++; $display("FAIL slow_aw_pass got=%b/%h want=1/0000", pass, err_count); end
    checks++; if (w_before_aw - wb0 != WC) begin failures++; $display("FAIL slow_aw_order got=%0d want=%0d", w_before_aw - wb0, WC); end
    aw_delay = 0; w_delay = 2; b_delay = 1;
    run_test(32'h5A5A_0000, cyc, to);
    checks++; if (to || pass !== 1'b1) begin failures++; $display("FAIL slow_w_pass got=%b timeout=%0d want=1", pass, to); end
    checks++; if (mem[3] !== 32'h5A5A_0003) begin failures++; $display("FAIL slow_w_mem3 got=%h want=5a5a0003", mem[3]); end
    checks++; if (sb_errs + proto_errs != 0) begin failures++; $display("FAIL slow_scoreboard got=%0d want=0", sb_errs + proto_errs); end
    aw_delay = 0; w_delay = 0; b_delay = 0;
  endtask

  task automatic test_rdata_corrupt();
    int cyc; bit to;
    corrupt_r = 4'b0100;
    run_test(32'h1000_0000, cyc, to);
    checks++; if (to) begin failures++; $display("FAIL corrupt1_timeout got=%0d want=done", cyc); end
    checks++; if ({pass, err_count} !== {1'b0, 16'd1}) begin failures++; $display("FAIL corrupt1_err got=%b/%h want=0/0001", pass, err_count); end
    checks++; if (fail_addr !== 16'h0008) begin failures++; $display("FAIL corrupt1_fail_addr got=%h want=0008", fail_addr); end
    corrupt_r = 4'b1100;
    run_test(32'h1000_0000, cyc, to);
    checks++; if ({to, pass, err_count} !== {1'b0, 1'b0, 16'd2}) begin failures++; $display("FAIL corrupt2_err got=%b/%b/%h want=0/0/0002", to, pass, err_count); end
    checks++; if (fail_addr !== 16'h0008) begin failures++; $display("FAIL corrupt2_fail_addr got=%h want=0008", fail_addr); end
    corrupt_r = '0;
  endtask

  task automatic test_resp_err();
    int cyc; bit to;
    bresp_err = 4'b0010; rresp_err = 4'b0010; corrupt_r = 4'b0010;
    run_test(32'hCAFE_0000, cyc, to);
    checks++; if ({to, pass, err_count} !== {1'b0, 1'b0, 16'd2}) begin failures++; $display("FAIL resp_err_count got=%b/%b/%h want=0/0/0002", to, pass, err_count); end
    checks++; if (fail_addr !== 16'h0004) begin failures++; $display("FAIL resp_fail_addr got=%h want=0004", fail_addr); end
    bresp_err = '0; rresp_err = '0; corrupt_r = '0;
  endtask

  task automatic test_start_ignored();
    int cyc; bit to;
    push_expected(32'h1000_0000);
    pulse_start(32'h1000_0000);
    repeat ($urandom_range(3, 6)) @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL restart_busy got=%b want=1", busy); end
    pulse_start(32'hFFFF_FFFF);
    wait_done(400, cyc, to);
    checks++; if ({to, pass, err_count} !== {1'b0, 1'b1, 16'd0}) begin failures++; $display("FAIL restart_ignored got=%b/%b/%h want=0/1/0000", to, pass, err_count); end
    checks++; if (mem[2] !== 32'h1000_0002) begin failures++; $display("FAIL restart_mem2 got=%h want=10000002", mem[2]); end
    checks++; if (exp_wr_q.size() + exp_rd_q.size() != 0) begin failures++; $display("FAIL restart_queue_left got=%0d want=0", exp_wr_q.size() + exp_rd_q.size()); end
    run_test(32'hFFFF_FFFF, cyc, to);
    checks++; if ({to, pass} !== 2'b01) begin failures++; $display("FAIL wrap_pass got=%b/%b want=0/1", to, pass); end
    checks++; if (mem[1] !== 32'h0000_0000 || mem[0] !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_mem got=%h,%h want=ffffffff,00000000", mem[0], mem[1]); end
    checks++; if (sb_errs + proto_errs != 0) begin failures++; $display("FAIL restart_scoreboard got=%0d want=0", sb_errs + proto_errs); end
  endtask

  task automatic test_reset_mid();
    int cyc; int n; bit to;
    b_delay = 5;
    push_expected(32'h2000_0000);
    pulse_start(32'h2000_0000);
    n = 0;
    while (!axil.bready && n < 20) begin @(negedge clk); n++; end
    checks++; if (!axil.bready) begin failures++; $display("FAIL midreset_reach_wr_resp got=%0d cycles want=bready", n); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({axil.awvalid, axil.wvalid, axil.bready, axil.arvalid, axil.rready} !== 5'b0) begin
      failures++; $display("FAIL midreset_valids got=%b want=00000", {axil.awvalid, axil.wvalid, axil.bready, axil.arvalid, axil.rready});
    end
    checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL midreset_flags got=%b want=00", {busy, done}); end
    @(negedge clk);
    exp_wr_q.delete(); exp_rd_q.delete();
    b_delay = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_test(32'h3000_0000, cyc, to);
    checks++; if ({to, pass, err_count} !== {1'b0, 1'b1, 16'd0}) begin failures++; $display("FAIL midreset_rerun got=%b/%b/%h want=0/1/0000", to, pass, err_count); end
    checks++; if (mem[3] !== 32'h3000_0003) begin failures++; $display("FAIL midreset_mem3 got=%h want=30000003", mem[3]); end
    checks++; if (sb_errs + proto_errs != 0) begin failures++; $display("FAIL midreset_scoreboard got=%0d want=0", sb_errs + proto_errs); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_clean();
    test_slow_aw();
    test_rdata_corrupt();
    test_resp_err();
    test_start_ignored();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axil_ram_bist.md
Name: axil_ram_bist

Overview:
AXI4-Lite master traffic generator and checker that sits directly upstream of axil_ram and drives its slave port. On start it writes a seeded incrementing pattern over a contiguous word range, reads every word back, and compares. It reports pass/fail, an error count and the first failing address. Used for bring-up self-test and as a closed-loop formal/simulation stimulus source for the RAM.

Parameters:
DATA_WIDTH, 32, data bus width in bits
ADDR_WIDTH, 16, address bus width in bits
STRB_WIDTH, DATA_WIDTH/8, wstrb width
BASE_ADDR, 0, byte address of first tested word; must be aligned to STRB_WIDTH
WORD_COUNT, 16, number of words tested; must be >= 1 and <= 65536

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin a test; ignored while busy
seed  in  DATA_WIDTH  pattern seed, sampled when start is accepted
busy  out  1  test in progress
done  out  1  sticky test-complete flag; cleared by next accepted start
pass  out  1  valid when done: 1 if err_count == 0
err_count  out  16  number of failing beats, saturating at 0xFFFF
fail_addr  out  ADDR_WIDTH  address of first failing beat; 0 if none
m_axil_awaddr/awprot/awvalid  out  ADDR_WIDTH/3/1  write address channel
m_axil_awready  in  1
m_axil_wdata/wstrb/wvalid  out  DATA_WIDTH/STRB_WIDTH/1  write data channel
m_axil_wready  in  1
m_axil_bresp  in  2 ; m_axil_bvalid in 1 ; m_axil_bready out 1
m_axil_araddr/arprot/arvalid  out  ADDR_WIDTH/3/1  read address channel
m_axil_arready  in  1
m_axil_rdata in DATA_WIDTH ; m_axil_rresp in 2 ; m_axil_rvalid in 1 ; m_axil_rready out 1

Behaviour:
- Reset (rst_n low, async): state IDLE; all valids, bready, rready, busy, done, pass = 0; err_count = 0; fail_addr = 0; index = 0.
- Word i: addr = BASE_ADDR + i*STRB_WIDTH (mod 2^ADDR_WIDTH); data = seed + i (mod 2^DATA_WIDTH). wstrb all ones; awprot = arprot = 3'b000.
- One transaction outstanding at a time; no read/write overlap.
- FSM states:
  - IDLE: on start, latch seed, clear done/pass/err_count/fail_addr, set busy, index = 0 -> WR.
  - WR: awvalid and wvalid asserted the cycle after entry (first cycle after start). Each is dropped independently in the cycle after its own handshake. Payload is held stable while valid. Once both have been accepted -> WR_RESP.
  - WR_RESP: bready = 1. On bvalid, bresp != 0 counts one error (fail_addr captured if first). If the last index -> index = 0, RD; else index + 1, WR.
  - RD: arvalid asserted; on arready -> RD_DATA.
  - RD_DATA: rready = 1. On rvalid, error if rresp != 0 or rdata != expected; a beat with both faults counts once. If the last index -> DONE_ST; else index + 1, RD.
  - DONE_ST: busy = 0, done = 1, pass = (err_count == 0) -> IDLE same cycle. done stays high until next start.
- Valid signals never deassert before handshake (AXI rule). Outputs are registered.
- err_count saturates at 0xFFFF and does not wrap. fail_addr is written only on the first error.
- start while busy: ignored, no effect on any state.
- awready/wready accepted in same or different cycles, in either order: both supported.
- Reset mid-operation: all valids drop immediately. The block makes no attempt to drain the slave; the system resets the RAM together with the block.
- Minimum test time with zero-wait slave: roughly 3 cycles per write + 2 per read per word.

Test Plan:
- WORD_COUNT=4, BASE_ADDR=0, seed=0x10000000, axil_ram downstream, always-ready -> writes 0x0/0x4/0x8/0xC with 0x10000000..0x10000003; reads match; done=1, pass=1, err_count=0, fail_addr=0.
- Same with slave asserting awready 3 cycles after wready and bvalid delayed 5 cycles -> wvalid drops after its handshake, awvalid held stable until accepted; pass=1.
- Slave model corrupts rdata at addr 0x8 -> err_count=1, fail_addr=0x0008, pass=0; bench also checks that a second corruption at 0xC leaves fail_addr unchanged and gives err_count=2.
- Slave returns bresp=2'b10 on addr 0x4 and rresp=2'b10 with wrong data on 0x4 -> err_count=2 (one write, one read), fail_addr=0x0004.
- start pulsed again mid-test with seed=0xFFFFFFFF -> ignored; original seed pattern completes, pass=1; seed=0xFFFFFFFF on next run wraps data to 0x00000000 at i=1.
- rst_n asserted during WR_RESP -> all valids, busy, done = 0 asynchronously; new start after release runs a full clean test, pass=1.
